// File: rtl/keychain_frame_rx_if.sv
// keychain_frame_rx_if: byte stream in, key register and message handshake out
interface keychain_frame_rx_if #(
    parameter int KEY_BYTES = 8,
    parameter int MSG_BYTES = 4
);
    logic                   byte_valid_in;
    logic [7:0]             byte_in;
    logic                   msg_ready_in;
    logic [8*KEY_BYTES-1:0] key_out;
    logic                   key_valid_out;
    logic                   key_loaded_out;
    logic [8*MSG_BYTES-1:0] msg_out;
    logic                   msg_valid_out;
    logic                   busy_out;
    logic                   err_out;
    logic [1:0]             err_code_out;
    logic [7:0]             drop_count_out;

    modport master (
        output byte_valid_in, byte_in, msg_ready_in,
        input  key_out, key_valid_out, key_loaded_out, msg_out, msg_valid_out,
               busy_out, err_out, err_code_out, drop_count_out
    );

    modport slave (
        input  byte_valid_in, byte_in, msg_ready_in,
        output key_out, key_valid_out, key_loaded_out, msg_out, msg_valid_out,
               busy_out, err_out, err_code_out, drop_count_out
    );
endinterface

// File: rtl/keychain_frame_rx.sv
// keychain_frame_rx: framed key/message receiver with XOR checksum, timeout and handshake
module keychain_frame_rx #(
    parameter int KEY_BYTES     = 8,
    parameter int MSG_BYTES     = 4,
    parameter int CLK_HZ        = 10_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int TIMEOUT_BYTES = 4
) (
    input logic                clk_in,
    input logic                rst_in,
    keychain_frame_rx_if.slave bus
);
    localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * CLK_HZ / BAUD_RATE;
    localparam int KW = 8 * KEY_BYTES;
    localparam int MW = 8 * MSG_BYTES;
    localparam int SW = KW > MW ? KW : MW;
    localparam int CW = $clog2(SW / 8) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {IDLE, KEY_PL, MSG_PL, CHECK, HOLD} state_t;

    state_t          state, state_nxt;
    logic            is_key, err_set, key_upd, msg_upd, timed, in_pl;
    logic [1:0]      err_nxt;
    logic [SW-1:0]   shadow;
    logic [7:0]      xsum;
    logic [CW-1:0]   cnt, last;
    logic [TW-1:0]   tcnt;

    wire       bv = bus.byte_valid_in;
    wire [7:0] b  = bus.byte_in;

    assign in_pl = state == KEY_PL || state == MSG_PL;
    assign timed = in_pl || state == CHECK;
    assign last  = is_key ? CW'(KEY_BYTES - 1) : CW'(MSG_BYTES - 1);

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_nxt   = 2'd0;
        key_upd   = 1'b0;
        msg_upd   = 1'b0;
        case (state)
            IDLE: if (bv) begin
                if (b == 8'hA5) state_nxt = KEY_PL;
                else if (b == 8'h5A && bus.key_loaded_out) state_nxt = MSG_PL;
                else begin
                    err_set = 1'b1;
                    err_nxt = b == 8'h5A ? 2'd0 : 2'd1;
                end
            end
            KEY_PL, MSG_PL: if (bv && cnt == last) state_nxt = CHECK;
            CHECK: if (bv) begin
                if (b == xsum) begin
                    key_upd   = is_key;
                    msg_upd   = !is_key;
                    state_nxt = is_key ? IDLE : HOLD;
                end else begin
                    err_set   = 1'b1;
                    err_nxt   = 2'd2;
                    state_nxt = IDLE;
                end
            end
            HOLD: if (bus.msg_valid_out && bus.msg_ready_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // a byte in the expiry cycle takes priority over the timeout
        if (timed && !bv && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            err_set   = 1'b1;
            err_nxt   = 2'd3;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state              <= IDLE;
            is_key             <= 1'b0;
            shadow             <= '0;
            xsum               <= '0;
            cnt                <= '0;
            tcnt               <= '0;
            bus.key_out        <= '0;
            bus.key_valid_out  <= 1'b0;
            bus.key_loaded_out <= 1'b0;
            bus.msg_out        <= '0;
            bus.msg_valid_out  <= 1'b0;
            bus.busy_out       <= 1'b0;
            bus.err_out        <= 1'b0;
            bus.err_code_out   <= 2'd0;
            bus.drop_count_out <= '0;
        end else begin
            state             <= state_nxt;
            bus.busy_out      <= state_nxt != IDLE;
            bus.key_valid_out <= key_upd;
            bus.err_out       <= err_set;
            if (err_set) bus.err_code_out <= err_nxt;
            tcnt <= timed && !bv ? tcnt + TW'(1) : '0;
            if (state == IDLE) begin
                cnt  <= '0;
                xsum <= '0;
                if (bv) is_key <= b == 8'hA5;
            end else if (in_pl && bv) begin
                shadow <= (shadow << 8) | SW'(b);
                xsum   <= xsum ^ b;
                cnt    <= cnt + CW'(1);
            end
            if (key_upd) begin
                bus.key_out        <= shadow[KW-1:0];
                bus.key_loaded_out <= 1'b1;
            end
            if (msg_upd) begin
                bus.msg_out       <= shadow[MW-1:0];
                bus.msg_valid_out <= 1'b1;
            end else if (bus.msg_valid_out && bus.msg_ready_in) begin
                bus.msg_valid_out <= 1'b0;
            end
            if (state == HOLD && bv && bus.drop_count_out != 8'hFF)
                bus.drop_count_out <= bus.drop_count_out + 8'd1;
        end
    end
endmodule

// File: tb/tb_keychain_frame_rx.sv
// tb_keychain_frame_rx: directed frames with queued expectations checked by a monitor
module tb_keychain_frame_rx;
    localparam int TCYC = 3472;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [63:0] key_q[$];
    logic [31:0] msg_q[$];
    logic [1:0]  err_q[$];
    logic        mv_prev = 1'b0;

    keychain_frame_rx_if #(.KEY_BYTES(8), .MSG_BYTES(4)) bus();

    keychain_frame_rx #(
        .KEY_BYTES(8), .MSG_BYTES(4), .CLK_HZ(10_000_000), .BAUD_RATE(115_200), .TIMEOUT_BYTES(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    always #50 clk_in = ~clk_in;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic unexpected(input string n);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event seen with no expectation queued", n);
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (bus.key_valid_out) begin
                if (key_q.size() == 0) unexpected("key_event");
                else chk("key_out", bus.key_out, key_q.pop_front());
            end
            if (bus.err_out) begin
                if (err_q.size() == 0) unexpected("err_event");
                else chk("err_code_out", 64'(bus.err_code_out), 64'(err_q.pop_front()));
            end
            if (bus.msg_valid_out && !mv_prev) begin
                if (msg_q.size() == 0) unexpected("msg_event");
                else chk("msg_out", 64'(bus.msg_out), 64'(msg_q.pop_front()));
            end
        end
        mv_prev = bus.msg_valid_out;
    end

    task automatic send(input logic [7:0] v);
        bus.byte_valid_in = 1'b1;
        bus.byte_in       = v;
        @(posedge clk_in);
        #1;
        bus.byte_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        bus.byte_valid_in = 1'b0;
        bus.byte_in       = 8'h00;
        bus.msg_ready_in  = 1'b0;
        idle(2);
        rst_in = 1'b0;
        chk("rst key_out", bus.key_out, 64'h0);
        chk("rst key_loaded", 64'(bus.key_loaded_out), 64'h0);
        chk("rst msg_valid", 64'(bus.msg_valid_out), 64'h0);
        chk("rst busy", 64'(bus.busy_out), 64'h0);
        chk("rst err_code", 64'(bus.err_code_out), 64'h0);
        chk("rst drop_count", 64'(bus.drop_count_out), 64'h0);
        // message header with no key loaded
        err_q.push_back(2'd0);
        send(8'h5A);
        chk("nokey busy", 64'(bus.busy_out), 64'h0);
        chk("nokey err_out", 64'(bus.err_out), 64'h1);
        idle(1);
        // bad header
        err_q.push_back(2'd1);
        send(8'h00);
        idle(1);
        chk("badhdr err_code hold", 64'(bus.err_code_out), 64'h1);
        // key load
        key_q.push_back(64'h0102030405060708);
        send(8'hA5);
        chk("key busy", 64'(bus.busy_out), 64'h1);
        for (int i = 1; i <= 8; i++) send(8'(i));
        send(8'h08);
        chk("key_loaded", 64'(bus.key_loaded_out), 64'h1);
        chk("key_valid pulse", 64'(bus.key_valid_out), 64'h1);
        idle(1);
        chk("key_valid one cycle", 64'(bus.key_valid_out), 64'h0);
        // message held, bytes dropped in HOLD
        msg_q.push_back(32'hDEADBEEF);
        send(8'h5A);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        send(8'hEF);
        send(8'h22);
        idle(2);
        chk("msg_valid held", 64'(bus.msg_valid_out), 64'h1);
        chk("msg_out held", 64'(bus.msg_out), 64'hDEADBEEF);
        send(8'h5A);
        send(8'h11);
        send(8'hA5);
        chk("drop_count", 64'(bus.drop_count_out), 64'h3);
        chk("hold busy", 64'(bus.busy_out), 64'h1);
        // header coinciding with the handshake is dropped
        bus.msg_ready_in = 1'b1;
        send(8'hA5);
        bus.msg_ready_in = 1'b0;
        chk("msg_valid after hs", 64'(bus.msg_valid_out), 64'h0);
        chk("drop on hs cycle", 64'(bus.drop_count_out), 64'h4);
        chk("idle after hs", 64'(bus.busy_out), 64'h0);
        idle(1);
        // bad checksum
        err_q.push_back(2'd2);
        send(8'hA5);
        repeat (8) send(8'h11);
        send(8'hFF);
        chk("badsum busy", 64'(bus.busy_out), 64'h0);
        idle(1);
        chk("badsum key kept", bus.key_out, 64'h0102030405060708);
        // timeout
        err_q.push_back(2'd3);
        send(8'hA5);
        send(8'h01);
        idle(TCYC - 1);
        chk("pre-timeout busy", 64'(bus.busy_out), 64'h1);
        idle(1);
        chk("timeout busy", 64'(bus.busy_out), 64'h0);
        chk("timeout err_out", 64'(bus.err_out), 64'h1);
        idle(2);
        // byte on the expiry cycle wins over the timeout
        key_q.push_back(64'h0102030405060708);
        send(8'hA5);
        send(8'h01);
        idle(TCYC - 1);
        for (int i = 2; i <= 8; i++) send(8'(i));
        send(8'h08);
        idle(1);
        chk("late byte err_code", 64'(bus.err_code_out), 64'h3);
        // reset mid-frame
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        chk("midrst key_loaded", 64'(bus.key_loaded_out), 64'h0);
        chk("midrst busy", 64'(bus.busy_out), 64'h0);
        key_q.push_back(64'h1011121314151617);
        send(8'hA5);
        for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
        send(8'h00);
        idle(3);
        chk("midrst err_code", 64'(bus.err_code_out), 64'h0);
        chk("key events left", 64'(key_q.size()), 64'h0);
        chk("msg events left", 64'(msg_q.size()), 64'h0);
        chk("err events left", 64'(err_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/keychain_frame_rx.md
# keychain_frame_rx

Parametrised UART command framer for the keychain datapath. It runs in the 10 MHz fabric domain between the UART byte receiver and the keychain core. It assembles framed "load key" and "message" packets of configurable length from a byte stream and checks an XOR checksum on each. It enforces an inter-byte timeout and presents the key as a register and each message through a valid/ready handshake, with error reporting.

## Interface
- KEY_BYTES, 8, key length in bytes (≥1)
- MSG_BYTES, 4, message length in bytes (≥1)
- CLK_HZ, 10_000_000, clk_in frequency
- BAUD_RATE, 115_200, UART line rate
- TIMEOUT_BYTES, 4, inter-byte timeout in byte-times; TIMEOUT_CYC = TIMEOUT_BYTES*10*CLK_HZ/BAUD_RATE (integer division, elaboration-time constant)
- clk_in  input  1  system clock
- rst_in  input  1  reset; one clock; reset is synchronous and active-high
- byte_valid_in  input  1  one-cycle strobe, byte_in valid
- byte_in  input  8  received byte
- msg_ready_in  input  1  downstream accepts msg_out
- key_out  output  8*KEY_BYTES  current key; first payload byte in MSBs
- key_valid_out  output  1  one-cycle pulse on key update
- key_loaded_out  output  1  level; a key has been loaded since reset
- msg_out  output  8*MSG_BYTES  message; first payload byte in MSBs
- msg_valid_out  output  1  level; msg_out held until accepted
- busy_out  output  1  high in any state other than IDLE
- err_out  output  1  one-cycle error pulse
- err_code_out  output  2  0 no key, 1 bad header, 2 bad checksum, 3 timeout; holds last code
- drop_count_out  output  8  saturating count of bytes dropped while in HOLD

## Operation
- Frame: header, payload, checksum. Header 0xA5 means key (KEY_BYTES payload). Header 0x5A means message (MSG_BYTES payload). Checksum = XOR of payload bytes only.
- States: IDLE, KEY_PL, MSG_PL, CHECK, HOLD.
- IDLE, byte 0xA5: go to KEY_PL.
- IDLE, byte 0x5A: go to MSG_PL if key_loaded_out. Otherwise error code 0 and stay in IDLE.
- IDLE, any other byte: error code 1, stay in IDLE.
- KEY_PL/MSG_PL: shift each byte into a shadow buffer (shift left by 8, new byte in LSBs). Running XOR is cleared on header acceptance. Byte counter runs 0..N-1. After byte N-1, go to CHECK.
- CHECK, byte equals running XOR, key frame: copy shadow to key_out, pulse key_valid_out, set key_loaded_out, go to IDLE.
- CHECK, byte equals running XOR, message frame: copy shadow to msg_out, assert msg_valid_out, go to HOLD.
- CHECK, mismatch: error code 2, go to IDLE. key_out and msg_out are unchanged.
- HOLD, when msg_valid_out && msg_ready_in: deassert msg_valid_out and go to IDLE.
- HOLD: every byte_valid_in is dropped and increments drop_count_out, saturating at 255. It is not an error.
- Timeout counter runs only in KEY_PL, MSG_PL and CHECK. It clears on each accepted byte and on entry to these states. When it reaches TIMEOUT_CYC-1 with no byte present: error code 3, go to IDLE, shadow discarded.
- Byte and timeout in the same cycle: the byte wins.
- msg_ready_in asserted while msg_valid_out is low has no effect.

## Timing
- Reset values: key_out 0, key_loaded_out 0, key_valid_out 0, msg_out 0, msg_valid_out 0, busy_out 0, err_out 0, err_code_out 0, drop_count_out 0. State IDLE, counters 0.
- Reset mid-frame discards the partial frame. It also clears the loaded key, and a pending message is lost.
- All outputs are registered.
- key_out, key_valid_out and key_loaded_out update in the cycle after the checksum strobe.
- msg_valid_out rises in the cycle after the checksum strobe. It falls in the cycle after the handshake.
- err_out and err_code_out update in the cycle after the offending strobe or timeout.
- A header strobe arriving in the same cycle the HOLD handshake completes is dropped, because the state is still HOLD in that cycle.
- Back-to-back strobes on consecutive cycles must be accepted. No throughput limit.

## Test plan
- Key load: A5, 01 02 03 04 05 06 07 08, 08 → key_out = 0x0102030405060708, one key_valid_out pulse, key_loaded_out = 1.
- Message before key (after reset): 5A → err_out pulse, err_code_out = 0, state stays IDLE, busy_out = 0.
- Message with handshake, key loaded: 5A, DE AD BE EF, 22 with msg_ready_in = 0 → msg_out = 0xDEADBEEF and msg_valid_out held. Feed 3 bytes → drop_count_out = 3. Raise msg_ready_in → msg_valid_out low in the next cycle.
- Bad checksum: A5, eight 0x11 bytes, 0xFF → err code 2, key_out unchanged.
- Bad header: 0x00 → err code 1.
- Timeout: A5, 01, then idle TIMEOUT_CYC cycles → err code 3, busy_out = 0. A byte arriving exactly on the timeout cycle is accepted instead of the error.
- Reset mid-frame: A5, 01, 02, rst_in for one cycle, then a full valid key frame → key_out equals the new frame, no error.
